// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Holds the scan FSM state encoding, the all-off segment value and the
// hex glyph table (segments {g,f,e,d,c,b,a}, active-low).
package disp_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Glyphs 0-9 then A, b, C, d, E, F.
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Content-load and display-pin bundle of the scan controller.
// master: content producer (drives digits/dp/digit_en/load, sees the pins).
// slave : scan controller (drives load_ack, frame_done, an, seg, dp_n).
interface display_scan_ctrl_if;

  logic [31:0] digits;
  logic [7:0]  dp;
  logic [7:0]  digit_en;
  logic        load;
  logic        load_ack;
  logic        frame_done;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  modport master (
    output digits, dp, digit_en, load,
    input  load_ack, frame_done, an, seg, dp_n
  );

  modport slave (
    input  digits, dp, digit_en, load,
    output load_ack, frame_done, an, seg, dp_n
  );

endinterface

// File: rtl/display_scan_ctrl_dec.sv
// 3-to-8 anode decoder, active-low: the selected anode is driven low.
// Latency: combinational. Backpressure: none.
// Ports: sel_i (digit index 0..7), an_o (anode enables, active-low).
module display_scan_ctrl_dec (
  input  logic [2:0] sel_i,
  output logic [7:0] an_o
);

  always_comb begin
    an_o        = 8'hFF;
    an_o[sel_i] = 1'b0;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scanner with a blanking gap per slot
// and double-buffered content. Pins (an/seg/dp_n) lag the scan state by one cycle.
// Backpressure: none; load is always accepted, latest staged data wins at the frame wrap.
// Ports: clk, reset (async, active-high); bus (slave): digits/dp/digit_en/load in,
// load_ack/frame_done/an/seg/dp_n out.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit LZ_SUPPRESS  = 1'b1
) (
  input logic               clk,
  input logic               reset,
  display_scan_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             pending_q, pending_d;
  logic [31:0]      stg_digits_q, sh_digits_q;
  logic [7:0]       stg_dp_q, sh_dp_q;
  logic [7:0]       stg_en_q, sh_en_q;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_n_q, dp_n_d;
  logic             load_ack_q, frame_done_q;

  logic [7:0] dec_an;
  logic [7:0] lead_zero;
  logic       zero_run;
  logic [3:0] nib;
  logic       lit;
  logic       frame_end;

  display_scan_ctrl_dec u_dec (
    .sel_i (sel_q),
    .an_o  (dec_an)
  );

  // Slot timing FSM: BLANK for the first BLANK_CYCLES of a slot, then SHOW.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    sel_d   = sel_q;
    case (state_q)
      BLANK: if (cnt_q == BLANK_LAST) state_d = SHOW;
      SHOW: begin
        if (cnt_q == CNT_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          sel_d   = sel_q + 3'd1;
        end
      end
      default: state_d = BLANK;
    endcase
  end

  assign frame_end = (state_q == SHOW) && (cnt_q == CNT_LAST) && (sel_q == 3'd7);

  // A load on the wrap edge re-arms pending; the transfer itself uses old staging.
  assign pending_d = bus.load ? 1'b1 : (frame_end ? 1'b0 : pending_q);

  // lead_zero[i]: shadow nibbles 7..i are all zero.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (sh_digits_q[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end
  end

  always_comb begin
    nib    = sh_digits_q[{sel_q, 2'b00} +: 4];
    lit    = (state_q == SHOW) && sh_en_q[sel_q] &&
             !(LZ_SUPPRESS && (sel_q != 3'd0) && lead_zero[sel_q]);
    an_d   = 8'hFF;
    seg_d  = SEG_BLANK;
    dp_n_d = 1'b1;
    if (lit) begin
      an_d   = dec_an;
      seg_d  = SEG_TABLE[nib];
      dp_n_d = ~sh_dp_q[sel_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      sel_q        <= '0;
      pending_q    <= 1'b0;
      stg_digits_q <= '0;
      stg_dp_q     <= '0;
      stg_en_q     <= '0;
      sh_digits_q  <= '0;
      sh_dp_q      <= '0;
      sh_en_q      <= '0;
      an_q         <= 8'hFF;
      seg_q        <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      load_ack_q   <= frame_end && pending_q;
      frame_done_q <= frame_end;
      if (bus.load) begin
        stg_digits_q <= bus.digits;
        stg_dp_q     <= bus.dp;
        stg_en_q     <= bus.digit_en;
      end
      if (frame_end && pending_q) begin
        sh_digits_q <= stg_digits_q;
        sh_dp_q     <= stg_dp_q;
        sh_en_q     <= stg_en_q;
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.load_ack   = load_ack_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two instances (LZ_SUPPRESS=1 and 0) share one
// stimulus stream; a cycle model queues the expected pin values per clock.
module tb_display_scan_ctrl;
  import disp_pkg::*;

  localparam int RD = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] in_digits = '0;
  logic [7:0]  in_dp = '0;
  logic [7:0]  in_en = '0;
  logic        in_load = 1'b0;

  display_scan_ctrl_if bus1();
  display_scan_ctrl_if bus0();

  assign bus1.digits = in_digits;
  assign bus1.dp = in_dp;
  assign bus1.digit_en = in_en;
  assign bus1.load = in_load;
  assign bus0.digits = in_digits;
  assign bus0.dp = in_dp;
  assign bus0.digit_en = in_en;
  assign bus0.load = in_load;

  display_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_SUPPRESS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  display_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_SUPPRESS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model state (value before the next clock edge).
  int          m_cnt = 0;
  int          m_sel = 0;
  bit          m_pending = 0;
  logic [31:0] m_stg_dig = '0, m_sh_dig = '0;
  logic [7:0]  m_stg_dp = '0, m_sh_dp = '0;
  logic [7:0]  m_stg_en = '0, m_sh_en = '0;

  logic [35:0] exp_q[$];

  localparam logic [17:0] OFF18 = {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0};

  function automatic logic [17:0] model_out(input bit lz, input bit bnd);
    logic       on;
    logic [3:0] n;
    logic [7:0] a;
    n  = m_sh_dig[m_sel*4 +: 4];
    on = (m_cnt >= BC) && m_sh_en[m_sel] &&
         !(lz && (m_sel != 0) && ((m_sh_dig >> (4*m_sel)) == 32'd0));
    a  = ~(8'd1 << m_sel);
    if (!on) return {8'hFF, SEG_BLANK, 1'b1, bnd && m_pending, bnd};
    return {a, SEG_TABLE[n], ~m_sh_dp[m_sel], bnd && m_pending, bnd};
  endfunction

  function automatic logic [35:0] obs();
    return {bus1.an, bus1.seg, bus1.dp_n, bus1.load_ack, bus1.frame_done,
            bus0.an, bus0.seg, bus0.dp_n, bus0.load_ack, bus0.frame_done};
  endfunction

  // Predict the outputs registered by the coming edge, advance the model, clock.
  task automatic tick();
    bit bnd;
    if (reset) begin
      exp_q.push_back({OFF18, OFF18});
      m_cnt = 0; m_sel = 0; m_pending = 0;
      m_stg_dig = '0; m_stg_dp = '0; m_stg_en = '0;
      m_sh_dig = '0; m_sh_dp = '0; m_sh_en = '0;
    end else begin
      bnd = (m_cnt == RD - 1) && (m_sel == 7);
      exp_q.push_back({model_out(1'b1, bnd), model_out(1'b0, bnd)});
      if (bnd && m_pending) begin
        m_sh_dig = m_stg_dig; m_sh_dp = m_stg_dp; m_sh_en = m_stg_en;
      end
      if (in_load) begin
        m_stg_dig = in_digits; m_stg_dp = in_dp; m_stg_en = in_en; m_pending = 1;
      end else if (bnd) begin
        m_pending = 0;
      end
      if (m_cnt == RD - 1) begin m_cnt = 0; m_sel = (m_sel + 1) % 8; end
      else m_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic [35:0] e;
    int fd1 = -1, fd2 = -1, lit = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin fails++; $display("FAIL reset_hold cyc%0d got %h exp %h", cyc, obs(), e); end
    end
    reset = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      tick(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin fails++; $display("FAIL idle_pins cyc%0d got %h exp %h", cyc, obs(), e); end
      if (bus1.an !== 8'hFF) lit++;
      if (bus1.frame_done === 1'b1) begin
        if (fd1 < 0) fd1 = k; else if (fd2 < 0) fd2 = k;
      end
    end
    checks++;
    if (fd1 != 8*RD) begin fails++; $display("FAIL first_frame_done got %0d exp %0d", fd1, 8*RD); end
    checks++;
    if (fd2 - fd1 != 8*RD) begin fails++; $display("FAIL frame_period got %0d exp %0d", fd2 - fd1, 8*RD); end
    checks++;
    if (lit != 0) begin fails++; $display("FAIL idle_dark got %0d lit cycles exp 0", lit); end
  endtask

  task automatic test_lz_suppress();
    logic [35:0] e;
    bit found = 0;
    int n_fe = 0, lit1 = 0, lit0 = 0;
    in_digits = 32'h0000_1234; in_en = 8'hFF; in_dp = 8'h04; in_load = 1'b1;
    tick(); e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin fails++; $display("FAIL lz_load cyc%0d got %h exp %h", cyc, obs(), e); end
    in_load = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin fails++; $display("FAIL lz_wait cyc%0d got %h exp %h", cyc, obs(), e); end
      if (bus1.frame_done === 1'b1) found = 1;
    end
    checks++;
    if (!found || bus1.load_ack !== 1'b1 || bus0.load_ack !== 1'b1) begin
      fails++; $display("FAIL lz_ack found=%0d ack=%b%b exp 1 11", found, bus1.load_ack, bus0.load_ack);
    end
    for (int k = 0; k < 8*RD; k++) begin
      tick(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin fails++; $display("FAIL lz_frame cyc%0d got %h exp %h", cyc, obs(), e); end
      if (bus1.an === 8'hFE) n_fe++;
      if (bus1.an !== 8'hFF) lit1++;
      if (bus0.an !== 8'hFF) lit0++;
    end
    checks++;
    if (n_fe != RD - BC) begin fails++; $display("FAIL lz_slot0_width got %0d exp %0d", n_fe, RD - BC); end
    checks++;
    if (lit1 != 4*(RD - BC)) begin fails++; $display("FAIL lz_lit got %0d exp %0d", lit1, 4*(RD - BC)); end
    checks++;
    if (lit0 != 8*(RD - BC)) begin fails++; $display("FAIL nolz_lit got %0d exp %0d", lit0, 8*(RD - BC)); end
  endtask

  task automatic test_enable_mask();
    logic [35:0] e;
    bit found = 0;
    int lit0 = 0, lit1 = 0, bad = 0;
    in_digits = 32'h0; in_en = 8'h81; in_dp = 8'h00; in_load = 1'b1;
    tick(); e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin fails++; $display("FAIL en_load cyc%0d got %h exp %h", cyc, obs(), e); end
    in_load = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin fails++; $display("FAIL en_wait cyc%0d got %h exp %h", cyc, obs(), e); end
      if (bus0.frame_done === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin fails++; $display("FAIL en_frame_timeout got 0 exp 1"); end
    for (int k = 0; k < 8*RD; k++) begin
      tick(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin fails++; $display("FAIL en_frame cyc%0d got %h exp %h", cyc, obs(), e); end
      if (bus0.an !== 8'hFF) begin
        lit0++;
        if (bus0.seg !== 7'b1000000 || (bus0.an !== 8'hFE && bus0.an !== 8'h7F)) bad++;
      end
      if (bus1.an !== 8'hFF) lit1++;
    end
    checks++;
    if (lit0 != 2*(RD - BC)) begin fails++; $display("FAIL en_lit got %0d exp %0d", lit0, 2*(RD - BC)); end
    checks++;
    if (bad != 0) begin fails++; $display("FAIL en_pattern got %0d bad cycles exp 0", bad); end
    checks++;
    if (lit1 != RD - BC) begin fails++; $display("FAIL en_lz_lit got %0d exp %0d", lit1, RD - BC); end
  endtask

  task automatic test_back_to_back();
    logic [35:0] e;
    int acks = 0, twos = 0;
    in_en = 8'hFF;
    for (int k = 0; k < 8*RD; k++) begin
      in_load = (k == 0 || k == 9);
      in_digits = (k < 9) ? 32'h1111_1111 : 32'h2222_2222;
      tick(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin fails++; $display("FAIL b2b_load cyc%0d got %h exp %h", cyc, obs(), e); end
      in_load = 1'b0;
      if (bus1.load_ack === 1'b1) acks++;
    end
    for (int k = 0; k < 8*RD; k++) begin
      tick(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin fails++; $display("FAIL b2b_frame cyc%0d got %h exp %h", cyc, obs(), e); end
      if (bus1.load_ack === 1'b1) acks++;
      if (bus0.an !== 8'hFF && bus0.seg === SEG_TABLE[2]) twos++;
    end
    checks++;
    if (acks != 1) begin fails++; $display("FAIL b2b_acks got %0d exp 1", acks); end
    checks++;
    if (twos != 8*(RD - BC)) begin fails++; $display("FAIL b2b_twos got %0d exp %0d", twos, 8*(RD - BC)); end
  endtask

  task automatic test_boundary_load();
    logic [35:0] e;
    int acks = 0, fives = 0, sixes = 0, guard = 0;
    in_digits = 32'h5555_5555; in_load = 1'b1;
    tick(); e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin fails++; $display("FAIL bnd_load_a cyc%0d got %h exp %h", cyc, obs(), e); end
    in_load = 1'b0;
    while (!(m_cnt == RD - 1 && m_sel == 7) && guard < 200) begin
      guard++;
      tick(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin fails++; $display("FAIL bnd_wait cyc%0d got %h exp %h", cyc, obs(), e); end
    end
    in_digits = 32'h6666_6666; in_load = 1'b1;
    tick(); e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin fails++; $display("FAIL bnd_edge cyc%0d got %h exp %h", cyc, obs(), e); end
    in_load = 1'b0;
    checks++;
    if (bus1.frame_done !== 1'b1 || bus1.load_ack !== 1'b1) begin
      fails++; $display("FAIL bnd_first_ack got fd=%b ack=%b exp 1 1", bus1.frame_done, bus1.load_ack);
    end
    for (int k = 0; k < 8*RD; k++) begin
      tick(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin fails++; $display("FAIL bnd_frame1 cyc%0d got %h exp %h", cyc, obs(), e); end
      if (bus1.load_ack === 1'b1) acks++;
      if (bus0.an !== 8'hFF && bus0.seg === SEG_TABLE[5]) fives++;
    end
    for (int k = 0; k < 8*RD; k++) begin
      tick(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin fails++; $display("FAIL bnd_frame2 cyc%0d got %h exp %h", cyc, obs(), e); end
      if (bus0.an !== 8'hFF && bus0.seg === SEG_TABLE[6]) sixes++;
    end
    checks++;
    if (acks != 1) begin fails++; $display("FAIL bnd_second_ack got %0d exp 1", acks); end
    checks++;
    if (fives != 8*(RD - BC)) begin fails++; $display("FAIL bnd_old_data got %0d exp %0d", fives, 8*(RD - BC)); end
    checks++;
    if (sixes != 8*(RD - BC)) begin fails++; $display("FAIL bnd_new_data got %0d exp %0d", sixes, 8*(RD - BC)); end
  endtask

  task automatic test_reset_mid();
    logic [35:0] e;
    int acks = 0, lit0 = 0, fds = 0, guard = 0;
    in_digits = 32'h7777_7777; in_en = 8'hFF; in_load = 1'b1;
    tick(); e = exp_q.pop_front(); checks++;
    if (obs() !== e) begin fails++; $display("FAIL rst_load cyc%0d got %h exp %h", cyc, obs(), e); end
    in_load = 1'b0;
    while (m_cnt != BC + 2 && guard < 20) begin
      guard++;
      tick(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin fails++; $display("FAIL rst_wait cyc%0d got %h exp %h", cyc, obs(), e); end
    end
    checks++;
    if (bus0.an === 8'hFF) begin fails++; $display("FAIL rst_precond an got %h exp lit", bus0.an); end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus1.an, bus1.seg, bus1.dp_n, bus0.an, bus0.seg, bus0.dp_n} !== {8'hFF, 7'h7F, 1'b1, 8'hFF, 7'h7F, 1'b1}) begin
      fails++; $display("FAIL rst_async got an=%h seg=%h dp_n=%b exp ff 7f 1", bus0.an, bus0.seg, bus0.dp_n);
    end
    for (int k = 0; k < 2; k++) begin
      tick(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin fails++; $display("FAIL rst_hold cyc%0d got %h exp %h", cyc, obs(), e); end
    end
    reset = 1'b0;
    for (int k = 0; k < 16*RD + 2; k++) begin
      tick(); e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin fails++; $display("FAIL rst_after cyc%0d got %h exp %h", cyc, obs(), e); end
      if (bus1.load_ack === 1'b1 || bus0.load_ack === 1'b1) acks++;
      if (bus0.an !== 8'hFF) lit0++;
      if (bus0.frame_done === 1'b1) fds++;
    end
    checks++;
    if (acks != 0) begin fails++; $display("FAIL rst_no_ack got %0d exp 0", acks); end
    checks++;
    if (lit0 != 0) begin fails++; $display("FAIL rst_shadow_clear got %0d lit exp 0", lit0); end
    checks++;
    if (fds != 2) begin fails++; $display("FAIL rst_frames got %0d exp 2", fds); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lz_suppress();
    test_enable_mask();
    test_back_to_back();
    test_boundary_load();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
